// File: rtl/varredura_matriz_leds_pkg.sv
// varredura_matriz_leds_pkg: shared sizes, column-index type and column-drive helpers
package varredura_matriz_leds_pkg;
    localparam int NUM_COL = 5;
    localparam int NUM_LIN = 7;

    typedef logic [2:0] col_idx_t;

    // Column drive with every column switched off, for either polarity.
    function automatic logic [NUM_COL-1:0] colunas_off(input bit ativa_baixo);
        return ativa_baixo ? '1 : '0;
    endfunction

    // One-hot drive of a single column, for either polarity.
    function automatic logic [NUM_COL-1:0] coluna_ativa(input col_idx_t c, input bit ativa_baixo);
        logic [NUM_COL-1:0] oh;
        oh = NUM_COL'(1) << c;
        return ativa_baixo ? ~oh : oh;
    endfunction
endpackage

// File: rtl/varredura_matriz_leds_divisor_de_varredura.sv
// divisor_de_varredura: column-slot prescaler
//   clock, reset_n : clock, asynchronous active-low reset
//   clr            : synchronous clear, holds the prescaler at 0
//   tick           : last cycle of the current column slot
//   em_blank       : slot is still inside its anti-ghosting blank window
module divisor_de_varredura #(
    parameter int DIV_SCAN = 50000,
    parameter int BLANK    = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    output logic tick,
    output logic em_blank
);
    localparam int PW = $clog2(DIV_SCAN);

    logic [PW-1:0] presc;

    assign tick     = presc == PW'(DIV_SCAN - 1);
    assign em_blank = presc < PW'(BLANK);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            presc <= '0;
        else
            presc <= (clr || tick) ? '0 : presc + 1'b1;
endmodule

// File: rtl/varredura_matriz_leds.sv
// varredura_matriz_leds: multiplexed 5x7 LED scan of a per-frame snapshot of the hit map with blinking cursor
//   clock, reset_n           : clock, asynchronous active-low reset
//   enable                   : 1 runs the scan, 0 blanks the display and restarts it
//   matriz0..matriz4         : hit map, one 7-bit row word per column
//   coordColuna, coordLinha  : live cursor coordinate
//   colunas, linhas          : registered column select and row data
//   frame_pulso              : one-cycle pulse when a snapshot is loaded
module varredura_matriz_leds
    import varredura_matriz_leds_pkg::*;
#(
    parameter int DIV_SCAN        = 50000,
    parameter int BLANK           = 64,
    parameter int BLINK_FRAMES    = 100,
    parameter bit COL_ATIVA_BAIXO = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NUM_LIN-1:0] matriz0,
    input  logic [NUM_LIN-1:0] matriz1,
    input  logic [NUM_LIN-1:0] matriz2,
    input  logic [NUM_LIN-1:0] matriz3,
    input  logic [NUM_LIN-1:0] matriz4,
    input  logic [2:0]         coordColuna,
    input  logic [2:0]         coordLinha,
    output logic [NUM_COL-1:0] colunas,
    output logic [NUM_LIN-1:0] linhas,
    output logic               frame_pulso
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic               tick, em_blank, fim_quadro, cursor, fim_blink;
    logic               fase, carregar;
    col_idx_t           col_idx;
    logic [BW-1:0]      blink;
    logic [NUM_LIN-1:0] matriz [NUM_COL];
    logic [NUM_LIN-1:0] snap   [NUM_COL];
    logic [NUM_COL-1:0] colunas_d;
    logic [NUM_LIN-1:0] linhas_d;

    assign matriz = '{matriz0, matriz1, matriz2, matriz3, matriz4};

    divisor_de_varredura #(.DIV_SCAN(DIV_SCAN), .BLANK(BLANK)) u_divisor (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (!enable),
        .tick     (tick),
        .em_blank (em_blank)
    );

    // Cursor coordinates are live; out-of-range values simply never match.
    always_comb begin
        fim_quadro = tick && col_idx == col_idx_t'(NUM_COL - 1);
        fim_blink  = blink == BW'(BLINK_FRAMES - 1);
        cursor     = !fase && coordColuna <= 3'(NUM_COL - 1) && coordLinha <= 3'(NUM_LIN - 1)
                     && coordColuna == col_idx;
        colunas_d  = em_blank ? colunas_off(COL_ATIVA_BAIXO) : coluna_ativa(col_idx, COL_ATIVA_BAIXO);
        linhas_d   = em_blank ? '0 : snap[col_idx] ^ (cursor ? NUM_LIN'(1) << coordLinha : '0);
    end

    // The snapshot loads on the first cycle of a frame, inside the blank window,
    // so a column is never driven from a half-updated map.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            col_idx     <= '0;
            blink       <= '0;
            fase        <= 1'b0;
            carregar    <= 1'b1;
            frame_pulso <= 1'b0;
            snap        <= '{default: '0};
            colunas     <= colunas_off(COL_ATIVA_BAIXO);
            linhas      <= '0;
        end else if (!enable) begin
            col_idx     <= '0;
            blink       <= '0;
            fase        <= 1'b0;
            carregar    <= 1'b1;
            frame_pulso <= 1'b0;
            colunas     <= colunas_off(COL_ATIVA_BAIXO);
            linhas      <= '0;
        end else begin
            frame_pulso <= carregar;
            if (carregar) begin
                snap     <= matriz;
                carregar <= 1'b0;
            end
            if (tick)
                col_idx <= col_idx == col_idx_t'(NUM_COL - 1) ? '0 : col_idx + 1'b1;
            if (fim_quadro) begin
                carregar <= 1'b1;
                blink    <= fim_blink ? '0 : blink + 1'b1;
                if (fim_blink)
                    fase <= ~fase;
            end
            colunas <= colunas_d;
            linhas  <= linhas_d;
        end
endmodule

// File: tb/tb_varredura_matriz_leds.sv
// tb_varredura_matriz_leds: randomized check of the LED scan against a frame-arithmetic reference model
module tb_varredura_matriz_leds;
    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int BF  = 2;
    localparam int FR  = 5 * DIV;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [6:0] mz [5];
    logic [2:0] coord_col, coord_lin;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       frame_pulso;

    int         n_cmp = 0;
    int         n_err = 0;
    int         k;
    logic [6:0] m_snap [5];

    always #5 clock = ~clock;

    varredura_matriz_leds #(.DIV_SCAN(DIV), .BLANK(BLK), .BLINK_FRAMES(BF), .COL_ATIVA_BAIXO(1'b1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .matriz0     (mz[0]),
        .matriz1     (mz[1]),
        .matriz2     (mz[2]),
        .matriz3     (mz[3]),
        .matriz4     (mz[4]),
        .coordColuna (coord_col),
        .coordLinha  (coord_lin),
        .colunas     (colunas),
        .linhas      (linhas),
        .frame_pulso (frame_pulso)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Model: k counts enabled edges since the last restart; frame, slot and
    // offset follow by division, the snapshot is taken at each frame start.
    task automatic step();
        int pos, slot, off, fr;
        bit cur;
        logic [4:0] e_col;
        logic [6:0] e_lin;
        logic       e_pul;
        if (!enable) begin
            e_col = 5'b11111;
            e_lin = '0;
            e_pul = 1'b0;
            k = 0;
        end else begin
            pos  = k % FR;
            slot = pos / DIV;
            off  = pos % DIV;
            fr   = k / FR;
            if (pos == 0)
                for (int c = 0; c < 5; c++) m_snap[c] = mz[c];
            e_pul = pos == 0;
            cur = ((fr / BF) % 2 == 0) && coord_col <= 4 && coord_lin <= 6 && int'(coord_col) == slot;
            if (off < BLK) begin
                e_col = 5'b11111;
                e_lin = '0;
            end else begin
                e_col = ~(5'(1) << slot);
                e_lin = m_snap[slot] ^ (cur ? 7'(1) << coord_lin : 7'd0);
            end
            k++;
        end
        @(posedge clock);
        #1;
        check("colunas", 32'(colunas), 32'(e_col));
        check("linhas", 32'(linhas), 32'(e_lin));
        check("frame_pulso", 32'(frame_pulso), 32'(e_pul));
        @(negedge clock);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_colunas", 32'(colunas), 32'h1f);
        check("rst_linhas", 32'(linhas), 32'h0);
        check("rst_pulso", 32'(frame_pulso), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        k = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mz[c] = '0;
            m_snap[c] = '0;
        end
        coord_col = 3'd7;
        coord_lin = 3'd7;
        k = 0;
        repeat (3) @(negedge clock);
        check("reset_colunas", 32'(colunas), 32'h1f);
        check("reset_linhas", 32'(linhas), 32'h0);
        check("reset_pulso", 32'(frame_pulso), 32'h0);

        mz[0] = 7'b1110001;
        mz[4] = 7'b1110000;
        reset_n = 1'b1;
        step();
        step();
        check("scan_c0_col", 32'(colunas), 32'(5'b11110));
        check("scan_c0_lin", 32'(linhas), 32'(7'b1110001));
        repeat (16) step();
        check("scan_c4_col", 32'(colunas), 32'(5'b01111));
        check("scan_c4_lin", 32'(linhas), 32'(7'b1110000));
        repeat (22) step();

        for (int c = 0; c < 5; c++) mz[c] = '0;
        coord_col = 3'd1;
        coord_lin = 3'd5;
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (6) step();
        check("cursor_on", 32'(linhas), 32'(7'b0100000));
        repeat (80) step();
        mz[1] = 7'b0100000;
        repeat (80) step();

        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (10) step();
        check("pre_rst_col2", 32'(colunas), 32'(5'b11011));
        async_reset();
        repeat (25) step();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) mz[$urandom_range(4)] = 7'($urandom);
            if ($urandom_range(15) == 0) begin
                coord_col = 3'($urandom);
                coord_lin = 3'($urandom);
            end
            enable = $urandom_range(24) != 0;
            if ($urandom_range(299) == 0) async_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
